// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: register file (r0 reads zero) feeding a stall/flush-capable ID/EX register.
// Optional same-edge write-back bypass enabled by defining ID_BYPASS_EN.
module id_stage_pipe #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned REGNUM  = 32,
    parameter int unsigned REGADDR = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        ir,
    input  logic               in_valid,
    input  logic               zext,
    input  logic               stall,
    input  logic               flush,
    input  logic               reg_wrt,
    input  logic [REGADDR-1:0] wrt_reg,
    input  logic [WIDTH-1:0]   wrt_dt,
    output logic [WIDTH-1:0]   read_data1,
    output logic [WIDTH-1:0]   read_data2,
    output logic [WIDTH-1:0]   offset,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [5:0]         opcode,
    output logic [4:0]         shamt,
    output logic [5:0]         funct,
    output logic               out_valid
);

    logic [WIDTH-1:0] regs [REGNUM];
    logic [4:0]       rs_q, rt_q;
    logic [4:0]       rs_sel, rt_sel;
    logic [WIDTH-1:0] rf_rs, rf_rt, op1_nxt, op2_nxt, offset_nxt;
    logic             wb_ok;

    // During a stall the operands re-read through the held indices, not the new ir.
    always_comb begin
        rs_sel = stall ? rs_q : ir[25:21];
        rt_sel = stall ? rt_q : ir[20:16];
        rf_rs  = '0;
        rf_rt  = '0;
        for (int unsigned i = 1; i < REGNUM; i++) begin
            if (rs_sel == 5'(i)) rf_rs = regs[i];
            if (rt_sel == 5'(i)) rf_rt = regs[i];
        end
        wb_ok = reg_wrt && (wrt_reg != '0) && (32'(wrt_reg) < REGNUM);
`ifdef ID_BYPASS_EN
        op1_nxt = (wb_ok && (32'(wrt_reg) == 32'(rs_sel))) ? wrt_dt : rf_rs;
        op2_nxt = (wb_ok && (32'(wrt_reg) == 32'(rt_sel))) ? wrt_dt : rf_rt;
`else
        op1_nxt = rf_rs;
        op2_nxt = rf_rt;
`endif
        offset_nxt = zext ? WIDTH'(ir[15:0]) : WIDTH'($signed(ir[15:0]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REGNUM; i++) regs[i] <= '0;
        end else if (wb_ok) begin
            for (int unsigned i = 1; i < REGNUM; i++)
                if (32'(wrt_reg) == i) regs[i] <= wrt_dt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            read_data1 <= '0;
            read_data2 <= '0;
            offset     <= '0;
            rt         <= '0;
            rd         <= '0;
            opcode     <= '0;
            shamt      <= '0;
            funct      <= '0;
            out_valid  <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
        end else if (stall) begin
            read_data1 <= op1_nxt;
            read_data2 <= op2_nxt;
        end else begin
            read_data1 <= op1_nxt;
            read_data2 <= op2_nxt;
            offset     <= offset_nxt;
            rt         <= ir[20:16];
            rd         <= ir[15:11];
            opcode     <= ir[31:26];
            shamt      <= ir[10:6];
            funct      <= ir[5:0];
            out_valid  <= in_valid;
            rs_q       <= ir[25:21];
            rt_q       <= ir[20:16];
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed, table-driven bench for id_stage_pipe (32-bit instance plus a 64-bit instance for extension).
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, zext, stall, flush, reg_wrt;
    logic [31:0] ir, wrt_dt;
    logic [4:0]  wrt_reg;

    logic [31:0] read_data1, read_data2, offset;
    logic [4:0]  rt, rd, shamt;
    logic [5:0]  opcode, funct;
    logic        out_valid;

    logic [63:0] rd1_64, rd2_64, off_64;
    logic [4:0]  rt_64, rd_64, shamt_64;
    logic [5:0]  opcode_64, funct_64;
    logic        ov_64;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .ir(ir), .in_valid(in_valid), .zext(zext),
        .stall(stall), .flush(flush), .reg_wrt(reg_wrt), .wrt_reg(wrt_reg),
        .wrt_dt(wrt_dt), .read_data1(read_data1), .read_data2(read_data2),
        .offset(offset), .rt(rt), .rd(rd), .opcode(opcode), .shamt(shamt),
        .funct(funct), .out_valid(out_valid)
    );

    id_stage_pipe #(.WIDTH(64), .REGNUM(32), .REGADDR(5)) u64 (
        .clk(clk), .rst(rst), .ir(ir), .in_valid(in_valid), .zext(zext),
        .stall(stall), .flush(flush), .reg_wrt(reg_wrt), .wrt_reg(wrt_reg),
        .wrt_dt({32'h0, wrt_dt}), .read_data1(rd1_64), .read_data2(rd2_64),
        .offset(off_64), .rt(rt_64), .rd(rd_64), .opcode(opcode_64), .shamt(shamt_64),
        .funct(funct_64), .out_valid(ov_64)
    );

    typedef struct {
        logic [31:0]  ir;
        logic         in_valid;
        logic         zext;
        logic         reg_wrt;
        logic [4:0]   wrt_reg;
        logic [31:0]  wrt_dt;
        logic [123:0] exp;
        logic [63:0]  off64;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [123:0] pk(input logic [31:0] d1, input logic [31:0] d2,
                                        input logic [31:0] off, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] op,
                                        input logic [4:0] sh, input logic [5:0] fn,
                                        input logic ov);
        return {d1, d2, off, t, d, op, sh, fn, ov};
    endfunction

    function automatic vec_t mkv(input logic [31:0] i, input logic v, input logic z,
                                 input logic w, input logic [4:0] wr, input logic [31:0] wd,
                                 input logic [123:0] e, input logic [63:0] o64);
        vec_t r;
        r.ir = i; r.in_valid = v; r.zext = z; r.reg_wrt = w;
        r.wrt_reg = wr; r.wrt_dt = wd; r.exp = e; r.off64 = o64;
        return r;
    endfunction

    function automatic logic [123:0] cur();
        return {read_data1, read_data2, offset, rt, rd, opcode, shamt, funct, out_valid};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic v, input logic st,
                         input logic fl, input logic w, input logic [4:0] wr,
                         input logic [31:0] wd);
        ir = i; in_valid = v; stall = st; flush = fl;
        reg_wrt = w; wrt_reg = wr; wrt_dt = wd;
    endtask

    logic [31:0] exp_same;
    logic [31:0] exp_stall2;

    initial begin
`ifdef ID_BYPASS_EN
        exp_same   = 32'h22;
        exp_stall2 = 32'h55;
`else
        exp_same   = 32'h11;
        exp_stall2 = 32'h0;
`endif
        vecs[0] = mkv(32'h8C22_0004, 1, 0, 0, 0, 0,
                      pk(0, 0, 32'h4, 2, 0, 6'h23, 0, 6'h04, 1), 64'h4);
        vecs[1] = mkv(32'h0, 0, 0, 1, 5, 32'hDEAD_BEEF,
                      pk(0, 0, 0, 0, 0, 0, 0, 0, 0), 64'h0);
        vecs[2] = mkv(32'h00A0_18A0, 1, 0, 1, 0, 32'h1234,
                      pk(32'hDEAD_BEEF, 0, 32'h18A0, 0, 3, 0, 2, 6'h20, 1), 64'h18A0);
        vecs[3] = mkv(32'h0, 1, 0, 0, 0, 0,
                      pk(0, 0, 0, 0, 0, 0, 0, 0, 1), 64'h0);
        vecs[4] = mkv(32'h3401_8000, 1, 0, 0, 0, 0,
                      pk(0, 0, 32'hFFFF_8000, 1, 5'h10, 6'h0D, 0, 0, 1), 64'hFFFF_FFFF_FFFF_8000);
        vecs[5] = mkv(32'h3401_8000, 1, 1, 0, 0, 0,
                      pk(0, 0, 32'h0000_8000, 1, 5'h10, 6'h0D, 0, 0, 1), 64'h8000);

        rst = 1'b1; zext = 1'b0;
        drive(32'h8C22_0004, 1, 0, 0, 0, 0, 0);
        step();
        step();
        chk("reset_outputs", {4'h0, cur()}, 128'h0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].ir, vecs[i].in_valid, 0, 0, vecs[i].reg_wrt,
                  vecs[i].wrt_reg, vecs[i].wrt_dt);
            zext = vecs[i].zext;
            step();
            chk($sformatf("vec%0d", i), {4'h0, cur()}, {4'h0, vecs[i].exp});
            chk($sformatf("vec%0d_off64", i), {64'h0, off_64}, {64'h0, vecs[i].off64});
        end
        zext = 1'b0;

        // same-edge write/read of r7
        drive(32'h0, 0, 0, 0, 1, 7, 32'h11);
        step();
        drive(32'h00E0_0000, 1, 0, 0, 1, 7, 32'h22);
        step();
        chk("same_edge_r7", {96'h0, read_data1}, {96'h0, exp_same});
        drive(32'h00E0_0000, 1, 0, 0, 0, 0, 0);
        step();
        chk("after_write_r7", {96'h0, read_data1}, 128'h22);

        // stall for three cycles, write r3 in the second
        drive(32'h8C62_0010, 1, 0, 0, 0, 0, 0);
        step();
        chk("stall_load", {4'h0, cur()}, {4'h0, pk(0, 0, 32'h10, 2, 0, 6'h23, 0, 6'h10, 1)});
        drive(32'hFFFF_FFFF, 0, 1, 0, 0, 0, 0);
        zext = 1'b1;
        step();
        chk("stall_c1", {4'h0, cur()}, {4'h0, pk(0, 0, 32'h10, 2, 0, 6'h23, 0, 6'h10, 1)});
        drive(32'hFFFF_FFFF, 0, 1, 0, 1, 3, 32'h55);
        step();
        chk("stall_c2", {4'h0, cur()},
            {4'h0, pk(exp_stall2, 0, 32'h10, 2, 0, 6'h23, 0, 6'h10, 1)});
        drive(32'hFFFF_FFFF, 0, 1, 0, 0, 0, 0);
        step();
        chk("stall_c3", {4'h0, cur()}, {4'h0, pk(32'h55, 0, 32'h10, 2, 0, 6'h23, 0, 6'h10, 1)});
        zext = 1'b0;

        // flush beats stall; write-back during the flush still lands
        drive(32'hFFFF_FFFF, 1, 1, 1, 1, 9, 32'h99);
        step();
        chk("flush_stall", {4'h0, cur()}, 128'h0);
        drive(32'hAD23_0008, 1, 0, 0, 0, 0, 0);
        step();
        chk("after_flush", {4'h0, cur()},
            {4'h0, pk(32'h99, 32'h55, 32'h8, 3, 0, 6'h2B, 0, 6'h08, 1)});

        // mid-stream reset clears register file and ID/EX
        rst = 1'b1;
        step();
        chk("midrst", {4'h0, cur()}, 128'h0);
        rst = 1'b0;
        drive(32'h0120_0000, 1, 0, 0, 0, 0, 0);
        step();
        chk("post_rst_r9", {4'h0, cur()}, {4'h0, pk(0, 0, 0, 0, 0, 0, 0, 0, 1)});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised, clocked successor of the instruction-decode stage. It holds a register file with synchronous write, with register 0 hardwired to zero, and decodes a 32-bit MIPS-format instruction. Decoded fields and operands go into an ID/EX pipeline register that supports stall and flush. It sits between the IF/ID instruction latch and the EX stage, and takes its write-back port from WB.

## Interface
- WIDTH, 32: data width of register file, operands and extended offset (≥16)
- REGNUM, 32: number of architectural registers (≤32)
- REGADDR, 5: register address width; must satisfy 2^REGADDR ≥ REGNUM
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ir  in  32  instruction word; fields opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0]
- in_valid  in  1  ir holds a real instruction
- zext  in  1  1 = zero-extend imm, 0 = sign-extend
- stall  in  1  hold ID/EX contents
- flush  in  1  insert bubble into ID/EX
- reg_wrt  in  1  write-back enable
- wrt_reg  in  REGADDR  write-back register index
- wrt_dt  in  WIDTH  write-back data
- read_data1, read_data2  out  WIDTH  registered rs/rt operands
- offset  out  WIDTH  registered extended immediate
- rt, rd  out  5  registered register indices
- opcode  out  6;  shamt  out  5;  funct  out  6  registered fields
- out_valid  out  1  ID/EX holds a valid instruction

## Operation
- Register file write: on a rising edge with reg_wrt=1 and wrt_reg≠0 and wrt_reg<REGNUM, REG[wrt_reg] ← wrt_dt. All other writes are ignored. REG[0] always reads 0.
- Combinational read: rs/rt index REG; an index ≥REGNUM reads 0.
- Offset: zext=1 gives {(WIDTH-16)'0, imm}; zext=0 gives {(WIDTH-16){imm[15]}, imm}.
- ID/EX update priority per edge is rst > flush > stall > load.
  - rst: every REG entry is 0 and every output is 0, including out_valid.
  - flush: all outputs go to 0 and out_valid goes to 0. The register file write still occurs.
  - stall: opcode, shamt, funct, rt, rd, offset and out_valid hold. read_data1/2 re-sample using the held rs/rt indices, which are kept internally, so a write-back during a stall is not lost.
  - load: every output captures the decode of ir; out_valid ← in_valid.
- There is no state machine. The state is the register file plus the ID/EX register.

## Timing
- Latency is 1 cycle: ir presented in cycle N appears on the outputs after edge N+1.
- Write visibility: a write at edge N is visible to a read issued in cycle N+1.
- A write and a read of the same register at the same edge follow the forwarding rule under Configuration.
- Simultaneous stall and flush: flush wins.
- rst asserted mid-stream clears in-flight state at that edge. The first load happens at the first edge with rst=0.
- A write-back to register 0 during a stall leaves the held operand at 0.

## Configuration
- ID_BYPASS_EN, when defined: if reg_wrt=1, wrt_reg≠0 and wrt_reg equals rs (or rt) at the same edge as a load or stall re-sample, the captured operand is wrt_dt. The write-back then needs no extra cycle.
- ID_BYPASS_EN, when undefined: the captured operand is the pre-write REG contents. The hazard unit must insert one stall.

## Test plan
- Reset: hold rst for 2 cycles, then present ir=0x8C22_0004 (lw, rs=1, rt=2) -> one cycle later read_data1=0, read_data2=0, offset=0x0000_0004, opcode=0x23, out_valid=1.
- Write then read: write 0xDEAD_BEEF to r5, next cycle present ir with rs=5 -> read_data1=0xDEAD_BEEF. A write of 0x1234 to r0 then a read of r0 -> 0.
- Extension: imm=0x8000 with zext=0 -> offset=0xFFFF_8000; with zext=1 -> 0x0000_8000. Repeat with WIDTH=64 -> 0xFFFF_FFFF_FFFF_8000.
- Same-edge write/read of r7 (old 0x11, new 0x22):
  - ID_BYPASS_EN defined -> read_data1=0x22.
  - ID_BYPASS_EN undefined -> read_data1=0x11.
- Stall: stall=1 for 3 cycles with r3 as rs, write 0x55 to r3 during the second cycle -> opcode, offset and out_valid hold, and read_data1 becomes 0x55.
- Flush: assert stall and flush together -> all outputs 0 and out_valid=0. Release both -> the next ir is decoded normally.
